// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state enum, parity constants and default width for the UART transmit controller
package uart_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } state_e;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// rtl/uart_tx_parity_calc.sv - combinational even/odd parity of the offered data word
module uart_tx_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  par_typ,
    output logic                  parity_bit
);

    // Even parity is the plain XOR reduction; odd parity is its inverse.
    always_comb begin
        parity_bit = ^p_data;
        if (par_typ == PAR_ODD) begin
            parity_bit = ~(^p_data);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame FSM with registered line, busy, shift-enable and done outputs
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop_two,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_bit_q, par_bit_d;
    logic             par_en_q, par_en_d;
    logic             stop_two_q, stop_two_d;
    logic             tx_out_q, tx_out_d;
    logic             busy_q, busy_d;
    logic             ser_en_q, ser_en_d;
    logic             tx_done_q, tx_done_d;
    logic             parity_now;

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .p_data     (p_data),
        .par_typ    (par_typ),
        .parity_bit (parity_now)
    );

    // Next-state, frame configuration capture and next-cycle output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        par_bit_d  = par_bit_q;
        par_en_d   = par_en_q;
        stop_two_d = stop_two_q;

        case (state_q)
            ST_IDLE: begin
                if (data_valid) begin
                    state_d    = ST_START;
                    cnt_d      = '0;
                    par_bit_d  = parity_now;
                    par_en_d   = par_en;
                    stop_two_d = stop_two;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: begin
                // The counter backs up ser_done so a silent serializer cannot stall the frame.
                if (ser_done || (cnt_q == CNT_LAST)) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: state_d = ST_STOP1;
            ST_STOP1:  state_d = stop_two_q ? ST_STOP2 : ST_IDLE;
            ST_STOP2:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with it once registered.
        case (state_d)
            ST_START:  tx_out_d = 1'b0;
            ST_DATA:   tx_out_d = ser_data;
            ST_PARITY: tx_out_d = par_bit_q;
            default:   tx_out_d = 1'b1;
        endcase
        busy_d    = (state_d != ST_IDLE);
        ser_en_d  = (state_d == ST_DATA);
        tx_done_d = (state_d == ST_STOP2) || ((state_d == ST_STOP1) && !stop_two_q);
    end

    // State, counter, latched configuration and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            stop_two_q <= 1'b0;
            tx_out_q   <= 1'b1;
            busy_q     <= 1'b0;
            ser_en_q   <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            stop_two_q <= stop_two_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
            ser_en_q   <= ser_en_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx_out  = tx_out_q;
    assign busy    = busy_q;
    assign ser_en  = ser_en_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl with frame-level reference model
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       stop_two = 1'b0;
    logic       ser_data;
    logic       ser_done;
    logic       ser_en;
    logic       tx_out;
    logic       busy;
    logic       tx_done;

    int n_checks = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .stop_two   (stop_two),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .tx_out     (tx_out),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    // Serializer stand-in: loads while idle, presents the bit for the next line cycle.
    logic [7:0] ser_word = 8'h00;
    int         ser_idx = 0;
    bit         ser_kill = 1'b0;

    always @(posedge clk) begin
        if (rst || !busy) begin
            ser_idx  <= 0;
            ser_word <= p_data;
        end else if (ser_en) begin
            ser_idx <= ser_idx + 1;
        end
    end

    always_comb begin
        int k;
        k = ser_idx + int'(ser_en);
        ser_data = 1'b0;
        if (k < 8) ser_data = ser_word[k[2:0]];
        ser_done = !ser_kill && ser_en && (ser_idx == 7);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one record per expected line cycle of the frame in flight.
    typedef struct packed {
        logic line;
        logic sen;
        logic done;
    } rec_t;

    rec_t exp_q[$];
    bit   model_idle;

    task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt, input logic st);
        int ones;
        ones = 0;
        exp_q.push_back('{line: 1'b0, sen: 1'b0, done: 1'b0});
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{line: d[i], sen: 1'b1, done: 1'b0});
            ones += int'(d[i]);
        end
        if (pe) exp_q.push_back('{line: ((ones % 2) == 1) ^ pt, sen: 1'b0, done: 1'b0});
        exp_q.push_back('{line: 1'b1, sen: 1'b0, done: !st});
        if (st) exp_q.push_back('{line: 1'b1, sen: 1'b0, done: 1'b1});
    endtask

    always @(posedge clk) begin
        model_idle = (exp_q.size() == 0);
        if (!model_idle) void'(exp_q.pop_front());
        if (rst) exp_q.delete();
        else if (model_idle && data_valid) build_frame(p_data, par_en, par_typ, stop_two);
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            if (exp_q.size() > 0) begin
                check("tx_out", 32'(tx_out), 32'(exp_q[0].line));
                check("busy", 32'(busy), 32'd1);
                check("ser_en", 32'(ser_en), 32'(exp_q[0].sen));
                check("tx_done", 32'(tx_done), 32'(exp_q[0].done));
            end else begin
                check("idle_tx_out", 32'(tx_out), 32'd1);
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_ser_en", 32'(ser_en), 32'd0);
                check("idle_tx_done", 32'(tx_done), 32'd0);
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic st);
        @(posedge clk);
        #1;
        p_data = d; par_en = pe; par_typ = pt; stop_two = st; data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic capture(input int n, output logic [31:0] line, output logic [31:0] done, output int bcnt);
        line = '0; done = '0; bcnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            line = (line << 1) | 32'(tx_out);
            done = (done << 1) | 32'(tx_done);
            bcnt += int'(busy);
        end
    endtask

    logic [31:0] ln, dn;
    int          bc;

    initial begin
        @(posedge clk);
        #1 cmp_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_tx_out", 32'(tx_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ser_en", 32'(ser_en), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        #1 rst = 1'b0;

        send(8'hA5, 1'b1, 1'b0, 1'b0);
        capture(11, ln, dn, bc);
        check("a5_line", ln, 32'b01010010101);
        check("a5_done", dn, 32'b00000000001);

        send(8'h01, 1'b1, 1'b1, 1'b0);
        capture(11, ln, dn, bc);
        check("odd_parity_01", 32'(ln[1]), 32'd0);
        send(8'h01, 1'b1, 1'b0, 1'b0);
        capture(11, ln, dn, bc);
        check("even_parity_01", 32'(ln[1]), 32'd1);

        send(8'hFF, 1'b0, 1'b0, 1'b1);
        capture(13, ln, dn, bc);
        check("ff_line", ln >> 2, 32'b01111111111);
        check("ff_busy_cycles", 32'(bc), 32'd11);

        // Late data_valid with different data while the frame is in DATA.
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        fork
            capture(11, ln, dn, bc);
            begin
                repeat (3) @(posedge clk);
                #1 p_data = 8'h3C; data_valid = 1'b1;
                @(posedge clk);
                #1 data_valid = 1'b0;
            end
        join
        check("ignore_valid_line", ln, 32'b01010010101);
        repeat (3) @(negedge clk);
        check("no_second_frame", 32'(busy), 32'd0);

        // Reset sampled at the end of the fourth DATA cycle.
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_tx_out", 32'(tx_out), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ser_en", 32'(ser_en), 32'd0);
        send(8'h5A, 1'b0, 1'b0, 1'b0);
        capture(10, ln, dn, bc);
        check("5a_line", ln, 32'b0010110101);

        // Configuration changes mid-frame must not leak into the frame.
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        fork
            capture(11, ln, dn, bc);
            begin
                repeat (2) @(posedge clk);
                #1 par_en = 1'b0; stop_two = 1'b1; par_typ = 1'b1;
            end
        join
        check("cfg_latched_line", ln, 32'b01010010101);
        check("cfg_latched_done", dn, 32'b00000000001);

        // Reset wins over data_valid in the same cycle.
        @(posedge clk);
        #1 rst = 1'b1; data_valid = 1'b1; p_data = 8'h77;
        @(posedge clk);
        #1 rst = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        check("rst_priority_busy", 32'(busy), 32'd0);

        // Silent serializer: the bit counter alone ends DATA.
        ser_kill = 1'b1;
        send(8'hC3, 1'b1, 1'b1, 1'b1);
        capture(12, ln, dn, bc);
        check("counter_exit_line", ln, 32'b011000011111);
        check("counter_exit_busy", 32'(bc), 32'd12);
        ser_kill = 1'b0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
